// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream burst packer.
package axis_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Registered output stage: one beat of data/last/len behind a valid flag.
// The upstream may load a new beat whenever ready_out_o is high.
module axis_out_reg #(
  parameter int DW = 32,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic [LW-1:0] len_i,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_valid_o,
  output logic          m_last_o,
  output logic [LW-1:0] m_len_o,
  output logic          ready_out_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          last_q;
  logic [LW-1:0] len_q;

  // Control bits: set on load, drop once the beat is taken with nothing new behind it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      len_q   <= len_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Data path is not reset; it is only meaningful while valid_q is set.
  always_ff @(posedge clk) begin
    if (load_i) data_q <= data_i;
  end

  assign ready_out_o = !valid_q || m_ready_i;
  assign m_data_o    = data_q;
  assign m_valid_o   = valid_q;
  assign m_last_o    = last_q;
  assign m_len_o     = len_q;

endmodule

// File: rtl/axis_burst_packer.sv
// Drains an upstream registered-output FIFO in whole bursts of BURST_LEN
// beats, or flushes a partial burst once data has waited TIMEOUT cycles.
// A burst only starts when the FIFO already holds every beat of it.
module axis_burst_packer
  import axis_pkg::*;
#(
  parameter int T_DATA_WIDTH = 32,
  parameter int SIZE         = 1024,
  parameter int BURST_LEN    = 16,
  parameter int TIMEOUT      = 256
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [T_DATA_WIDTH-1:0]   s_data_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [$clog2(SIZE):0]     fifo_usedw_i,
  output logic [T_DATA_WIDTH-1:0]   m_data_o,
  output logic                      m_valid_o,
  output logic                      m_last_o,
  output logic [$clog2(BURST_LEN):0] m_len_o,
  input  logic                      m_ready_i,
  output logic                      timeout_flush_o
);

  localparam int UW = $clog2(SIZE) + 1;
  localparam int AW = UW + 1;
  localparam int LW = $clog2(BURST_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  burst_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic          flush_q, flush_d;

  logic [AW-1:0] avail;
  logic          ready_out;
  logic          load;
  logic          last_beat;

  // fifo_usedw_i excludes the word sitting in the FIFO output register.
  assign avail     = AW'(fifo_usedw_i) + AW'(s_valid_i);
  assign last_beat = (beat_q == LW'(len_q - LW'(1)));

  // State, idle timer, burst length and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  // Burst decision in idle; beat sequencing while bursting.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    len_d     = len_q;
    beat_d    = beat_q;
    flush_d   = 1'b0;
    s_ready_o = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (avail >= AW'(BURST_LEN)) begin
          // Full burst wins over a coincident timeout, with no flush pulse.
          len_d   = LW'(BURST_LEN);
          timer_d = '0;
          state_d = ST_BURST;
        end else if (avail != '0 && timer_q == TW'(TIMEOUT - 1)) begin
          len_d   = LW'(avail);
          flush_d = 1'b1;
          timer_d = '0;
          state_d = ST_BURST;
        end else if (avail != '0) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = '0;
        end
      end
      ST_BURST: begin
        s_ready_o = ready_out;
        if (s_valid_i && ready_out) begin
          load = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + LW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  axis_out_reg #(
    .DW(T_DATA_WIDTH),
    .LW(LW)
  ) u_out_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .data_i     (s_data_i),
    .last_i     (last_beat),
    .len_i      (len_q),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_last_o   (m_last_o),
    .m_len_o    (m_len_o),
    .ready_out_o(ready_out)
  );

  assign timeout_flush_o = flush_q;

  a_len_max: assert property (@(posedge clk) disable iff (!reset_n)
    m_len_o <= LW'(BURST_LEN));

  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
    m_valid_o && !m_ready_i |=> m_valid_o && $stable(m_data_o) &&
                                $stable(m_last_o) && $stable(m_len_o));

  a_flush_idle: assert property (@(posedge clk) disable iff (!reset_n)
    timeout_flush_o |-> $past(state_q) == ST_IDLE);

endmodule

// File: tb/tb_axis_burst_packer.sv
// Bench for axis_burst_packer: table of directed packet scenarios, a few
// hand-written timing corners, and a randomized stream scored against a
// queue-based model of the upstream FIFO and the expected beat order.
module tb_axis_burst_packer;

  localparam int DW   = 32;
  localparam int SIZE = 16;
  localparam int BL   = 4;
  localparam int TO   = 8;
  localparam int UW   = $clog2(SIZE) + 1;
  localparam int LW   = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [UW-1:0] fifo_usedw_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  logic [LW-1:0] m_len_o;
  logic          m_ready_i;
  logic          timeout_flush_o;

  axis_burst_packer #(
    .T_DATA_WIDTH(DW), .SIZE(SIZE), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .fifo_usedw_i(fifo_usedw_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_len_o(m_len_o), .m_ready_i(m_ready_i),
    .timeout_flush_o(timeout_flush_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nwords;
    int npkts;
    int last_len;
    int nflush;
    bit rnd;
  } vec_t;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] push_q[$];
  logic [DW-1:0] exp_q[$];
  int            pkt_lens[$];
  int            checks, failures, cyc, flushes, flush_cyc, first_vis;
  int            cur_beats, cur_len, gap_max;
  bit            first_pending, rnd_rdy, rdy_force, acc_in, acc_out;
  logic [DW-1:0] cap_data;
  logic          cap_last;
  logic [LW-1:0] cap_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present the head of the FIFO model like a registered-output FIFO.
  task automatic drive_fifo();
    s_valid_i    = (fifo_q.size() > 0);
    s_data_i     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    fifo_usedw_i = (fifo_q.size() > 0) ? UW'(fifo_q.size() - 1) : '0;
  endtask

  // One clock: retire handshakes of the previous cycle, score beats, drive new inputs.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (acc_in && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (acc_out) begin
      if (exp_q.size() == 0) check("beat_unexpected", cap_data, 64'hDEAD);
      else check("beat_data", cap_data, exp_q.pop_front());
      cur_beats++;
      if (cur_beats == 1) cur_len = int'(cap_len);
      else check("len_const", cap_len, cur_len);
      if (cap_last) begin
        check("len_match", cap_len, cur_beats);
        pkt_lens.push_back(cur_beats);
        cur_beats = 0;
      end else begin
        check("last_missing", (cur_beats < int'(cap_len)), 1);
      end
    end
    if (timeout_flush_o) begin
      flushes++;
      flush_cyc = cyc;
    end
    if (push_q.size() > 0 && fifo_q.size() < SIZE &&
        (gap_max == 0 || $urandom_range(gap_max, 0) == 0)) begin
      logic [DW-1:0] w;
      w = push_q.pop_front();
      fifo_q.push_back(w);
      exp_q.push_back(w);
      if (first_pending) begin
        first_vis     = cyc + 1;
        first_pending = 0;
      end
    end
    m_ready_i = rnd_rdy ? (($urandom & 1) != 0) : rdy_force;
    drive_fifo();
    #1;
    acc_in   = s_valid_i && s_ready_o;
    acc_out  = m_valid_o && m_ready_i;
    cap_data = m_data_o;
    cap_last = m_last_o;
    cap_len  = m_len_o;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (!(push_q.size() == 0 && fifo_q.size() == 0 && !m_valid_o) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) check("drain_budget", k, 0);
    repeat (12) tick();
  endtask

  task automatic start_case(input bit rnd);
    pkt_lens.delete();
    flushes       = 0;
    rnd_rdy       = rnd;
    rdy_force     = 1'b1;
    gap_max       = 0;
    first_pending = 1;
  endtask

  task automatic run_case(input string tag, input int n, input logic [DW-1:0] base,
                          input bit rnd, input int npk, input int last_len, input int nfl);
    start_case(rnd);
    for (int i = 0; i < n; i++) push_q.push_back(base + DW'(i));
    drain(400);
    check({tag, "_npkts"}, pkt_lens.size(), npk);
    if (pkt_lens.size() > 0) check({tag, "_last_len"}, pkt_lens[$], last_len);
    check({tag, "_flushes"}, flushes, nfl);
    check({tag, "_all_out"}, exp_q.size(), 0);
    if (nfl == 1 && n < BL && !rnd)
      check({tag, "_flush_latency"}, flush_cyc - first_vis, TO - 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [DW-1:0] snap_data;
    logic          snap_last;
    logic [LW-1:0] snap_len;
    int            k, nshort;

    checks = 0; failures = 0; cyc = 0; flushes = 0; flush_cyc = 0; first_vis = 0;
    cur_beats = 0; cur_len = 0; gap_max = 0; first_pending = 0;
    rnd_rdy = 0; rdy_force = 1; acc_in = 0; acc_out = 0;
    cap_data = '0; cap_last = 0; cap_len = '0;
    reset_n = 1'b0; m_ready_i = 1'b1;
    drive_fifo();

    //           nwords npkts last_len nflush rnd
    vecs[0] = '{ 4,     1,    4,       0,     1'b0 };
    vecs[1] = '{ 3,     1,    3,       1,     1'b0 };
    vecs[2] = '{ 10,    3,    2,       1,     1'b1 };
    vecs[3] = '{ 8,     2,    4,       0,     1'b1 };
    vecs[4] = '{ 1,     1,    1,       1,     1'b0 };
    vecs[5] = '{ 5,     2,    1,       1,     1'b1 };

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_last", m_last_o, 0);
    check("rst_m_len", m_len_o, 0);
    check("rst_flush", timeout_flush_o, 0);
    check("rst_s_ready", s_ready_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 6; v++)
      run_case($sformatf("vec%0d", v), vecs[v].nwords, DW'(32'h100 * (v + 1)),
               vecs[v].rnd, vecs[v].npkts, vecs[v].last_len, vecs[v].nflush);

    // Fourth word becomes visible on the same edge the idle timer reaches TIMEOUT-1.
    start_case(1'b0);
    push_q.push_back(32'h40);
    tick();
    push_q.push_back(32'h41);
    push_q.push_back(32'h42);
    tick();
    tick();
    repeat (4) tick();
    push_q.push_back(32'h43);
    tick();
    drain(200);
    check("race_npkts", pkt_lens.size(), 1);
    if (pkt_lens.size() > 0) check("race_len", pkt_lens[0], 4);
    check("race_flushes", flushes, 0);

    // Downstream stall of 20 cycles in the middle of a packet.
    start_case(1'b0);
    for (int i = 0; i < 4; i++) push_q.push_back(32'h50 + i);
    k = 0;
    while (!(m_valid_o && cap_data == 32'h51) && k < 60) begin
      tick();
      k++;
    end
    check("stall_reached", k < 60, 1);
    rdy_force = 1'b0;
    tick();
    snap_data = m_data_o;
    snap_last = m_last_o;
    snap_len  = m_len_o;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid", m_valid_o, 1);
      check("stall_data", m_data_o, snap_data);
      check("stall_last", m_last_o, snap_last);
      check("stall_len", m_len_o, snap_len);
      check("stall_s_ready", s_ready_o, 0);
    end
    rdy_force = 1'b1;
    drain(200);
    check("stall_npkts", pkt_lens.size(), 1);
    if (pkt_lens.size() > 0) check("stall_len_out", pkt_lens[0], 4);
    check("stall_all_out", exp_q.size(), 0);

    // Random arrivals and random backpressure; a short packet must always come with a flush.
    start_case(1'b1);
    gap_max = 3;
    for (int i = 0; i < 60; i++) push_q.push_back(32'h1000 + i);
    drain(3000);
    gap_max = 0;
    check("rnd_all_out", exp_q.size(), 0);
    nshort = 0;
    k = 0;
    foreach (pkt_lens[i]) begin
      if (pkt_lens[i] < BL) nshort++;
      k += pkt_lens[i];
      check("rnd_len_range", (pkt_lens[i] >= 1 && pkt_lens[i] <= BL), 1);
    end
    check("rnd_beats", k, 60);
    check("rnd_short_vs_flush", nshort, flushes);

    // Asynchronous reset while a beat is parked on the output.
    start_case(1'b0);
    rdy_force = 1'b0;
    for (int i = 0; i < 4; i++) push_q.push_back(32'h60 + i);
    k = 0;
    while (!m_valid_o && k < 60) begin
      tick();
      k++;
    end
    check("arst_pre_valid", m_valid_o, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid_o, 0);
    check("arst_m_last", m_last_o, 0);
    check("arst_m_len", m_len_o, 0);
    check("arst_flush", timeout_flush_o, 0);
    check("arst_s_ready", s_ready_o, 0);
    fifo_q.delete();
    push_q.delete();
    exp_q.delete();
    cur_beats = 0;
    acc_in = 0;
    acc_out = 0;
    drive_fifo();
    #1;
    reset_n = 1'b1;
    rdy_force = 1'b1;
    tick();
    tick();
    check("post_rst_s_ready", s_ready_o, 0);
    check("post_rst_m_valid", m_valid_o, 0);
    run_case("post_rst", 4, 32'h70, 1'b0, 1, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
